// File: rtl/bnn_l1_initiator_if.sv
// bnn_l1_initiator_if: CFU-L1 request/response bus between an initiator and a fixed-latency CFU
interface bnn_l1_initiator_if #(
    parameter int CFU_FUNC_ID_W = 1,
    parameter int CFU_DATA_W    = 32
);
    logic                     cfu_clk_en;
    logic                     req_valid;
    logic [CFU_FUNC_ID_W-1:0] req_func;
    logic [CFU_DATA_W-1:0]    req_data0;
    logic [CFU_DATA_W-1:0]    req_data1;
    logic                     resp_valid;
    logic [1:0]               resp_status;
    logic [CFU_DATA_W-1:0]    resp_data;
    modport master (
        output cfu_clk_en, req_valid, req_func, req_data0, req_data1,
        input  resp_valid, resp_status, resp_data
    );
    modport slave (
        input  cfu_clk_en, req_valid, req_func, req_data0, req_data1,
        output resp_valid, resp_status, resp_data
    );
endinterface

// File: rtl/bnn_l1_initiator.sv
// bnn_l1_initiator: streams (activation, weight) pairs into a CFU-L1 BNN CFU and sums the responses
module bnn_l1_initiator #(
    parameter int CFU_LATENCY   = 0,
    parameter int CFU_FUNC_ID_W = 1,
    parameter int CFU_DATA_W    = 32,
    parameter int FUNC          = 0,
    parameter int LEN_W         = 16,
    parameter int ACC_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CFU_DATA_W-1:0] in_x,
    input  logic [CFU_DATA_W-1:0] in_w,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W-1:0]      result,
    output logic                  err,
    bnn_l1_initiator_if.master    cfu
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [LEN_W:0] ONE = 1;
    state_t             state, state_n;
    logic [LEN_W:0]     len_q, issued, received, rcv_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic               accept, resp_take;
    if (ACC_W < CFU_DATA_W || CFU_LATENCY < 0) begin : g_param_check
        $error("bnn_l1_initiator: invalid parameters");
    end
    assign accept         = in_valid & in_ready;
    assign resp_take      = cfu.resp_valid && state != IDLE && received != issued;
    assign cfu.cfu_clk_en = ~rst;
    assign cfu.req_func   = CFU_FUNC_ID_W'(FUNC);
    // the response that completes the job is folded in here so DONE follows it directly
    always_comb begin
        rcv_n = resp_take ? received + ONE : received;
        acc_n = resp_take ? acc + ACC_W'($signed(cfu.resp_data)) : acc;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state == IDLE ? (start ? (len == '0 ? DONE : RUN) : IDLE) :
                  state == RUN  ? (rcv_n == len_q ? DONE : RUN) : IDLE;
    end
    always_comb begin
        in_ready = state == RUN && issued < len_q;
        busy     = state == RUN;
        done     = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            issued        <= '0;
            received      <= '0;
            acc           <= '0;
            result        <= '0;
            err           <= 1'b0;
            cfu.req_valid <= 1'b0;
            cfu.req_data0 <= '0;
            cfu.req_data1 <= '0;
        end else begin
            cfu.req_valid <= accept;
            if (accept) begin
                cfu.req_data0 <= in_x;
                cfu.req_data1 <= in_w;
                issued        <= issued + ONE;
            end
            if (state == IDLE) begin
                if (start) begin
                    len_q    <= {1'b0, len};
                    issued   <= '0;
                    received <= '0;
                    acc      <= '0;
                    result   <= '0;
                    err      <= 1'b0;
                end
            end else begin
                acc      <= acc_n;
                received <= rcv_n;
                if (cfu.resp_valid && (cfu.resp_status != 2'd0 || received == issued)) err <= 1'b1;
                if (state == RUN && rcv_n == len_q) result <= acc_n;
            end
        end
    end
endmodule

// File: tb/tb_bnn_l1_initiator.sv
// tb_bnn_l1_initiator: directed jobs against a latency-configurable BNN CFU model and a job-level scoreboard
module tb_bnn_l1_initiator;
    logic        clk = 0, rst = 1, start = 0, in_valid = 0;
    logic [15:0] len = 0;
    logic [31:0] in_x = 0, in_w = 0;
    logic        in_ready, busy, done, err;
    logic [31:0] result;
    int          vectors = 0, miscompares = 0, cyc = 0;
    bit          chk_on = 0;
    int          lat = 0, pushes = 0, bad_push = -1, spur_at = -1;
    logic [31:0] px[8], pw[8];
    bit          m_busy = 0, m_req_v = 0, m_err = 0;
    int          m_acc = 0, m_len = 0, m_done_at = -1;
    logic [31:0] m_sum = 0, m_result = 0, m_x = 0, m_w = 0;
    typedef struct { int due; logic [31:0] d; logic [1:0] s; } rsp_t;
    rsp_t q[$];

    bnn_l1_initiator_if #(.CFU_FUNC_ID_W(1), .CFU_DATA_W(32)) cfu ();

    bnn_l1_initiator #(.CFU_LATENCY(0), .CFU_FUNC_ID_W(1), .CFU_DATA_W(32), .FUNC(0), .LEN_W(16), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .busy(busy), .done(done), .result(result), .err(err), .cfu(cfu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // XNOR-popcount dot product of 32 {-1,+1} weights
    function automatic logic [31:0] bnn(input logic [31:0] x, input logic [31:0] w);
        return 32'(2 * $countones(~(x ^ w)) - 32);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // per-cycle compare, CFU responder and job-level model
    always @(negedge clk) begin
        logic        rv, sp, acc;
        logic [31:0] rd;
        logic [1:0]  rs;
        if (chk_on) begin
            chk("busy", busy, m_busy);
            chk("in_ready", in_ready, m_busy && m_acc < m_len);
            chk("done", done, cyc == m_done_at);
            chk("req_valid", cfu.req_valid, m_req_v);
            if (m_req_v) begin
                chk("req_data0", cfu.req_data0, m_x);
                chk("req_data1", cfu.req_data1, m_w);
            end
            chk("result", result, m_result);
            chk("err", err, m_err);
            chk("cfu_clk_en", cfu.cfu_clk_en, !rst);
        end
        if (cfu.req_valid === 1'b1) begin
            pushes++;
            q.push_back('{cyc + lat, bnn(cfu.req_data0, cfu.req_data1), (pushes == bad_push) ? 2'd1 : 2'd0});
        end
        rv = 0; sp = 0; rd = 0; rs = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            rv = 1; rd = q[0].d; rs = q[0].s;
            void'(q.pop_front());
        end else if (cyc == spur_at) begin
            rv = 1; sp = 1; rd = 32'd100;
        end
        cfu.resp_valid  = rv;
        cfu.resp_data   = rd;
        cfu.resp_status = rs;
        if (rv && m_busy && (rs != 0 || sp)) m_err = 1;
        if (rst) begin
            m_busy = 0; m_done_at = -1; m_req_v = 0; m_result = 0; m_err = 0; m_acc = 0; m_len = 0;
        end else begin
            acc = m_busy && in_valid && m_acc < m_len;
            m_req_v = acc;
            if (acc) begin
                m_x = in_x; m_w = in_w; m_acc++;
                m_sum += bnn(in_x, in_w);
                if (m_acc == m_len) m_done_at = cyc + 2 + lat;
            end
            if (!m_busy && cyc != m_done_at && start) begin
                m_sum = 0; m_err = 0; m_result = 0; m_acc = 0; m_len = int'(len);
                if (len == 0) m_done_at = cyc + 1;
                else begin m_busy = 1; m_done_at = -1; end
            end
            if (cyc + 1 == m_done_at) begin m_busy = 0; m_result = m_sum; end
        end
    end

    task automatic run_job(input int n, input int lt, input logic [7:0] pat, input int npat, input bit mid,
                           input int spur_off, output int sc, output int fa, output int la, output int dc);
        int idx;
        idx = 0; lat = lt; start = 1; len = 16'(n); sc = cyc;
        tick;
        start = 0; fa = -1; la = -1;
        for (int i = 0; i < npat; i++) begin
            in_valid = pat[i];
            if (pat[i]) begin
                in_x = px[idx]; in_w = pw[idx]; idx++;
                if (fa < 0) begin
                    fa = cyc;
                    if (spur_off >= 0) spur_at = cyc + spur_off;
                end
                la = cyc;
            end
            if (mid && i == 0) begin start = 1; len = 16'd5; end
            tick;
            start = 0;
        end
        in_valid = 0; dc = -1;
        for (int k = 0; k < 40 && dc < 0; k++) begin
            if (done) dc = cyc;
            else tick;
        end
        if (dc < 0) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: no done within 40 cycles, required one");
        end
        tick;
    endtask

    initial begin
        int sc, fa, la, dc;
        tick;
        chk_on = 1;
        tick;
        chk("rst_busy", busy, 0); chk("rst_result", result, 0); chk("rst_req_valid", cfu.req_valid, 0);
        chk("rst_in_ready", in_ready, 0); chk("rst_clk_en", cfu.cfu_clk_en, 0);
        rst = 0;
        tick;
        chk("clk_en_run", cfu.cfu_clk_en, 1);
        // back-to-back, L=0: 32, -32, 0, 10
        px[0] = 32'h5A5A5A5A; pw[0] = 32'h5A5A5A5A; px[1] = 0; pw[1] = 32'hFFFFFFFF;
        px[2] = 0; pw[2] = 32'h0000FFFF; px[3] = 0; pw[3] = 32'h000007FF;
        run_job(4, 0, 8'b1111, 4, 0, -1, sc, fa, la, dc);
        chk("j1_result", result, 32'd10); chk("j1_err", err, 0); chk("j1_done_cycle", dc, fa + 5);
        // L=2, in_valid toggled: 32, 30, -32
        px[0] = 32'hFFFF0000; pw[0] = 32'hFFFF0000; px[1] = 0; pw[1] = 32'h1;
        px[2] = 32'hAAAAAAAA; pw[2] = 32'h55555555;
        run_job(3, 2, 8'b10101, 5, 0, -1, sc, fa, la, dc);
        chk("j2_result", result, 32'd30); chk("j2_done_cycle", dc, la + 4);
        // len=0
        run_job(0, 0, 8'b0, 0, 0, -1, sc, fa, la, dc);
        chk("j3_result", result, 0); chk("j3_done_cycle", dc, sc + 1);
        // start during RUN ignored: 26 + 32
        px[0] = 0; pw[0] = 32'h7; px[1] = 0; pw[1] = 0;
        run_job(2, 1, 8'b11, 2, 1, -1, sc, fa, la, dc);
        chk("j4_result", result, 32'd58); chk("j4_done_cycle", dc, la + 3);
        // bad status on 2nd response, still accumulated: 32 + 24 + 16
        bad_push = pushes + 2;
        px[0] = 0; pw[0] = 0; px[1] = 0; pw[1] = 32'hF; px[2] = 0; pw[2] = 32'hFF;
        run_job(3, 1, 8'b111, 3, 0, -1, sc, fa, la, dc);
        chk("j5_result", result, 32'd72); chk("j5_err", err, 1);
        // a new job clears err
        px[0] = 0; pw[0] = 32'hFFFFFFFF;
        run_job(1, 0, 8'b1, 1, 0, -1, sc, fa, la, dc);
        chk("j6_result", result, 32'hFFFFFFE0); chk("j6_err", err, 0);
        // spurious response in RUN with nothing outstanding: 32 + 28
        px[0] = 0; pw[0] = 0; px[1] = 0; pw[1] = 32'h3;
        run_job(2, 0, 8'b1001, 4, 0, 2, sc, fa, la, dc);
        chk("j7_result", result, 32'd60); chk("j7_err", err, 1);
        spur_at = cyc + 2;
        repeat (4) tick;
        chk("idle_spur_result", result, 32'd60); chk("idle_spur_err", err, 1);
        // reset mid-job with 2 requests outstanding, L=3
        lat = 3; start = 1; len = 16'd4;
        tick;
        start = 0; in_valid = 1; in_x = 0; in_w = 0;
        tick;
        in_w = 32'h1;
        tick;
        in_valid = 0; rst = 1;
        tick;
        rst = 0;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_req_valid", cfu.req_valid, 0); chk("mid_rst_result", result, 0);
        chk("mid_rst_err", err, 0); chk("mid_rst_done", done, 0); chk("mid_rst_in_ready", in_ready, 0);
        repeat (6) tick;
        px[0] = 0; pw[0] = 0; px[1] = 0; pw[1] = 32'h1;
        run_job(2, 0, 8'b11, 2, 0, -1, sc, fa, la, dc);
        chk("j8_result", result, 32'd62); chk("j8_err", err, 0);
        repeat (2) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
